// File: rtl/spi_frame_sched.sv
// Frame scheduler for the SPI trace transmitter: packs bytes into 16-bit words,
// double-buffers whole frames and hands them word by word to the transmitter.
module spi_frame_sched #(
    parameter int FRAME_WORDS = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        transmitIn,
    output logic [15:0] tx_word,
    input  logic        tx_free,
    input  logic        rxFrameReset,
    output logic [15:0] frames_sent,
    output logic [7:0]  abort_count
);

    localparam int IW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int AW = $clog2(2 * FRAME_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ARMED, SEND} state_t;

    // dClk-domain inputs: bit 0 = tx_free, bit 1 = rxFrameReset
    logic [1:0] async_in;
    logic [1:0] edge_pulse;
    assign async_in = {rxFrameReset, tx_free};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            logic                   prev_reg;
            logic                   pulse_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    chain_reg <= '0;
                    prev_reg  <= 1'b0;
                    pulse_reg <= 1'b0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};
                    prev_reg  <= chain_reg[SYNC_STAGES-1];
                    pulse_reg <= chain_reg[SYNC_STAGES-1] & ~prev_reg;
                end
            end

            assign edge_pulse[gi] = pulse_reg;
        end
    endgenerate

    logic tx_free_pulse;
    logic frame_reset_pulse;
    assign tx_free_pulse     = edge_pulse[0];
    assign frame_reset_pulse = edge_pulse[1];

    // Fill side
    logic          phase_reg;
    logic [7:0]    lo_byte_reg;
    logic [IW-1:0] fill_idx_reg;
    logic          fill_sel_reg;
    logic [1:0]    full_reg;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;
    logic          accept;
    logic          word_wr;
    logic          fill_done;

    assign in_ready  = ~(full_reg[0] & full_reg[1]);
    assign accept    = in_valid & in_ready;
    assign word_wr   = accept & phase_reg;
    assign fill_done = word_wr & (fill_idx_reg == LAST_IDX);
    assign full_set  = fill_done ? (fill_sel_reg ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg    <= 1'b0;
            lo_byte_reg  <= '0;
            fill_idx_reg <= '0;
            fill_sel_reg <= 1'b0;
        end else if (accept) begin
            if (!phase_reg) begin
                lo_byte_reg <= in_byte;
                phase_reg   <= 1'b1;
            end else begin
                phase_reg <= 1'b0;
                if (fill_idx_reg == LAST_IDX) begin
                    fill_idx_reg <= '0;
                    fill_sel_reg <= ~fill_sel_reg;
                end else begin
                    fill_idx_reg <= fill_idx_reg + 1'b1;
                end
            end
        end
    end

    // Ping-pong storage: buffer b occupies addresses b*FRAME_WORDS .. +FRAME_WORDS-1
    logic [15:0]   mem [0:2*FRAME_WORDS-1];
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic          rd_sel;
    logic [IW-1:0] rd_idx;

    assign wr_addr = AW'(fill_idx_reg) + (fill_sel_reg ? AW'(FRAME_WORDS) : AW'(0));

    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[wr_addr] <= {in_byte, lo_byte_reg};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_word <= '0;
        end else if (rd_en) begin
            tx_word <= mem[rd_addr];
        end
    end

    // Drain side
    state_t        state_reg;
    logic [IW-1:0] drain_idx_reg;
    logic          drain_sel_reg;
    logic          active;
    logic          start;
    logic          replay;
    logic          advance;
    logic          complete;
    logic          next_full;

    assign active    = (state_reg == ARMED) || (state_reg == SEND);
    assign start     = (state_reg == IDLE) && full_reg[drain_sel_reg];
    assign replay    = active & frame_reset_pulse;
    assign advance   = active & tx_free_pulse & ~frame_reset_pulse;
    assign complete  = advance & (drain_idx_reg == LAST_IDX);
    assign full_clr  = complete ? (drain_sel_reg ? 2'b10 : 2'b01) : 2'b00;
    // A frame finishing filling in this very cycle still counts as ready to send
    assign next_full = full_reg[~drain_sel_reg] | full_set[~drain_sel_reg];

    always_comb begin
        rd_sel  = drain_sel_reg;
        rd_idx  = '0;
        rd_en   = start | replay | (advance & ~(complete & ~next_full));
        if (complete) begin
            rd_sel = ~drain_sel_reg;
        end else if (advance) begin
            rd_idx = drain_idx_reg + 1'b1;
        end
        rd_addr = AW'(rd_idx) + (rd_sel ? AW'(FRAME_WORDS) : AW'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            transmitIn    <= 1'b0;
            drain_idx_reg <= '0;
            drain_sel_reg <= 1'b0;
            full_reg      <= '0;
            frames_sent   <= '0;
            abort_count   <= '0;
        end else begin
            full_reg <= (full_reg | full_set) & ~full_clr;
            if (start) begin
                state_reg     <= ARMED;
                transmitIn    <= 1'b1;
                drain_idx_reg <= '0;
            end else if (replay) begin
                state_reg     <= ARMED;
                drain_idx_reg <= '0;
                if (abort_count != 8'hFF) begin
                    abort_count <= abort_count + 1'b1;
                end
            end else if (complete) begin
                frames_sent   <= frames_sent + 1'b1;
                drain_sel_reg <= ~drain_sel_reg;
                drain_idx_reg <= '0;
                if (next_full) begin
                    state_reg <= ARMED;
                end else begin
                    state_reg  <= IDLE;
                    transmitIn <= 1'b0;
                end
            end else if (advance) begin
                drain_idx_reg <= drain_idx_reg + 1'b1;
                state_reg     <= SEND;
            end else if (!active && state_reg != IDLE) begin
                state_reg  <= IDLE;
                transmitIn <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_sched.sv
// Randomised bench for spi_frame_sched; expectations come from a queue-of-words
// model of what the transmitter should see.
module tb_spi_frame_sched;

    localparam int FW = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        transmitIn;
    logic [15:0] tx_word;
    logic        tx_free;
    logic        rxFrameReset;
    logic [15:0] frames_sent;
    logic [7:0]  abort_count;

    spi_frame_sched #(.FRAME_WORDS(FW), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .transmitIn   (transmitIn),
        .tx_word      (tx_word),
        .tx_free      (tx_free),
        .rxFrameReset (rxFrameReset),
        .frames_sent  (frames_sent),
        .abort_count  (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: words accepted but not yet sent; the first FW of them are the current frame
    logic [15:0] word_q[$];
    logic [7:0]  pend_byte;
    bit          pend;
    int          m_idx;
    logic [15:0] m_frames;
    logic [7:0]  m_abort;
    logic [15:0] exp_w;

    function automatic bit m_ready();
        return word_q.size() < 2 * FW;
    endfunction

    function automatic bit m_armed();
        return word_q.size() >= FW;
    endfunction

    task automatic model_clear();
        word_q.delete();
        pend     = 0;
        m_idx    = 0;
        m_frames = '0;
        m_abort  = '0;
    endtask

    task automatic model_push(input logic [7:0] b);
        if (pend) begin
            word_q.push_back({b, pend_byte});
            pend = 0;
        end else begin
            pend_byte = b;
            pend      = 1;
        end
    endtask

    task automatic model_tx();
        if (m_armed()) begin
            if (m_idx == FW - 1) begin
                m_frames = m_frames + 16'd1;
                repeat (FW) void'(word_q.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic model_rfr();
        if (m_armed()) begin
            m_idx = 0;
            if (m_abort != 8'hFF) m_abort = m_abort + 8'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; tx_free = 1'b0; rxFrameReset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit ok;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        ok = m_ready();
        @(posedge clk);
        if (ok) model_push(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)));
    endtask

    // Async pulses about 1/40 of clk rate; simultaneous assertion means frame reset wins
    task automatic pulse(input bit tx, input bit rf);
        @(negedge clk);
        #2;
        tx_free = tx; rxFrameReset = rf;
        repeat (4) @(negedge clk);
        tx_free = 1'b0; rxFrameReset = 1'b0;
        repeat (36) @(negedge clk);
        if (rf) model_rfr();
        else if (tx) model_tx();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (transmitIn !== 1'b0) begin bad++; $display("FAIL reset_transmitIn: got %0b want 0", transmitIn); end
        total++; if (tx_word !== 16'h0) begin bad++; $display("FAIL reset_tx_word: got %h want 0000", tx_word); end
        total++; if (frames_sent !== 16'h0) begin bad++; $display("FAIL reset_frames: got %0d want 0", frames_sent); end
        total++; if (abort_count !== 8'h0) begin bad++; $display("FAIL reset_abort: got %0d want 0", abort_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        $display("test_reset: checked reset values");
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        @(posedge clk); @(negedge clk);
        total++; if (transmitIn !== 1'b1) begin bad++; $display("FAIL basic_arm: transmitIn=%0b want 1", transmitIn); end
        total++; if (tx_word !== 16'h0100) begin bad++; $display("FAIL basic_word0_const: tx_word=%h want 0100", tx_word); end
        for (int k = 0; k < FW; k++) begin
            exp_w = word_q[m_idx];
            total++; if (tx_word !== exp_w) begin bad++; $display("FAIL basic_word%0d: tx_word=%h want %h", k, tx_word, exp_w); end
            total++; if (transmitIn !== 1'b1) begin bad++; $display("FAIL basic_hold%0d: transmitIn=%0b want 1", k, transmitIn); end
            pulse(1, 0);
        end
        total++; if (frames_sent !== m_frames) begin bad++; $display("FAIL basic_frames: got %0d want %0d", frames_sent, m_frames); end
        total++; if (transmitIn !== 1'b0) begin bad++; $display("FAIL basic_idle: transmitIn=%0b want 0", transmitIn); end
        $display("test_basic: frames_sent=%0d", frames_sent);
    endtask

    task automatic test_full();
        do_reset();
        push_random(32);
        total++; if (in_ready !== m_ready()) begin bad++; $display("FAIL full_in_ready: got %0b want %0b", in_ready, m_ready()); end
        push_byte(8'($urandom_range(0, 255)));
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready33: got %0b want 0", in_ready); end
        for (int k = 0; k < FW; k++) begin
            exp_w = word_q[m_idx];
            total++; if (tx_word !== exp_w) begin bad++; $display("FAIL full_f0_word%0d: tx_word=%h want %h", k, tx_word, exp_w); end
            pulse(1, 0);
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after: got %0b want 1", in_ready); end
        total++; if (transmitIn !== 1'b1) begin bad++; $display("FAIL full_stay_armed: transmitIn=%0b want 1", transmitIn); end
        for (int k = 0; k < FW; k++) begin
            exp_w = word_q[m_idx];
            total++; if (tx_word !== exp_w) begin bad++; $display("FAIL full_f1_word%0d: tx_word=%h want %h", k, tx_word, exp_w); end
            pulse(1, 0);
        end
        total++; if (frames_sent !== m_frames) begin bad++; $display("FAIL full_frames: got %0d want %0d", frames_sent, m_frames); end
        // A fresh frame must start on an even byte, proving byte 33 was refused
        push_random(16);
        @(posedge clk); @(negedge clk);
        exp_w = word_q[0];
        total++; if (tx_word !== exp_w) begin bad++; $display("FAIL full_fresh_word0: tx_word=%h want %h", tx_word, exp_w); end
        $display("test_full: frames_sent=%0d", frames_sent);
    endtask

    task automatic test_replay();
        do_reset();
        push_random(16);
        @(posedge clk); @(negedge clk);
        repeat (3) pulse(1, 0);
        pulse(0, 1);
        exp_w = word_q[0];
        total++; if (tx_word !== exp_w) begin bad++; $display("FAIL replay_word0: tx_word=%h want %h", tx_word, exp_w); end
        total++; if (abort_count !== m_abort) begin bad++; $display("FAIL replay_abort: got %0d want %0d", abort_count, m_abort); end
        total++; if (transmitIn !== 1'b1) begin bad++; $display("FAIL replay_armed: transmitIn=%0b want 1", transmitIn); end
        for (int k = 0; k < FW; k++) begin
            exp_w = word_q[m_idx];
            total++; if (tx_word !== exp_w) begin bad++; $display("FAIL replay_word%0d: tx_word=%h want %h", k, tx_word, exp_w); end
            pulse(1, 0);
        end
        total++; if (frames_sent !== m_frames) begin bad++; $display("FAIL replay_frames: got %0d want %0d", frames_sent, m_frames); end
        $display("test_replay: abort_count=%0d frames_sent=%0d", abort_count, frames_sent);
    endtask

    task automatic test_simultaneous();
        do_reset();
        push_random(16);
        @(posedge clk); @(negedge clk);
        repeat (2) pulse(1, 0);
        pulse(1, 1);
        exp_w = word_q[0];
        total++; if (tx_word !== exp_w) begin bad++; $display("FAIL simul_word0: tx_word=%h want %h", tx_word, exp_w); end
        total++; if (abort_count !== m_abort) begin bad++; $display("FAIL simul_abort: got %0d want %0d", abort_count, m_abort); end
        pulse(1, 0);
        exp_w = word_q[m_idx];
        total++; if (tx_word !== exp_w) begin bad++; $display("FAIL simul_word1: tx_word=%h want %h", tx_word, exp_w); end
        for (int k = 1; k < FW; k++) pulse(1, 0);
        total++; if (frames_sent !== m_frames) begin bad++; $display("FAIL simul_frames: got %0d want %0d", frames_sent, m_frames); end
        $display("test_simultaneous: abort_count=%0d", abort_count);
    endtask

    task automatic test_idle();
        do_reset();
        push_random(5);
        pulse(1, 0);
        pulse(0, 1);
        total++; if (transmitIn !== 1'b0) begin bad++; $display("FAIL idle_transmitIn: got %0b want 0", transmitIn); end
        total++; if (frames_sent !== m_frames) begin bad++; $display("FAIL idle_frames: got %0d want %0d", frames_sent, m_frames); end
        total++; if (abort_count !== m_abort) begin bad++; $display("FAIL idle_abort: got %0d want %0d", abort_count, m_abort); end
        push_random(11);
        @(posedge clk); @(negedge clk);
        total++; if (transmitIn !== 1'b1) begin bad++; $display("FAIL idle_arm: transmitIn=%0b want 1", transmitIn); end
        for (int k = 0; k < FW; k++) begin
            exp_w = word_q[m_idx];
            total++; if (tx_word !== exp_w) begin bad++; $display("FAIL idle_word%0d: tx_word=%h want %h", k, tx_word, exp_w); end
            pulse(1, 0);
        end
        total++; if (frames_sent !== m_frames) begin bad++; $display("FAIL idle_frames_end: got %0d want %0d", frames_sent, m_frames); end
        $display("test_idle: frames_sent=%0d", frames_sent);
    endtask

    task automatic test_rst_mid();
        do_reset();
        push_random(32);
        repeat (FW) pulse(1, 0);
        pulse(0, 1);
        repeat (4) pulse(1, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (transmitIn !== 1'b0) begin bad++; $display("FAIL rstmid_transmitIn: got %0b want 0", transmitIn); end
        total++; if (tx_word !== 16'h0) begin bad++; $display("FAIL rstmid_tx_word: got %h want 0000", tx_word); end
        total++; if (frames_sent !== 16'h0) begin bad++; $display("FAIL rstmid_frames: got %0d want 0", frames_sent); end
        total++; if (abort_count !== 8'h0) begin bad++; $display("FAIL rstmid_abort: got %0d want 0", abort_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
        rst = 1'b0;
        model_clear();
        push_random(16);
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < FW; k++) begin
            exp_w = word_q[m_idx];
            total++; if (tx_word !== exp_w) begin bad++; $display("FAIL rstmid_word%0d: tx_word=%h want %h", k, tx_word, exp_w); end
            pulse(1, 0);
        end
        total++; if (frames_sent !== m_frames) begin bad++; $display("FAIL rstmid_frames_end: got %0d want %0d", frames_sent, m_frames); end
        $display("test_rst_mid: frames_sent=%0d", frames_sent);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_byte = '0; tx_free = 1'b0; rxFrameReset = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_full();
        test_replay();
        test_simultaneous();
        test_idle();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
